// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM access controller: default widths,
// arbitration state encoding and the conflict rule.
package dpram_pkg;

  localparam int unsigned DefAddrW = 2;
  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Read/read at one address is harmless; anything involving a write is not.
  function automatic logic is_conflict(input logic valid_a, input logic valid_b,
                                       input logic we_a, input logic we_b,
                                       input logic addr_eq);
    return valid_a & valid_b & addr_eq & (we_a | we_b);
  endfunction

endpackage

// File: rtl/dpram_core.sv
// Dual-port storage: two synchronous write ports and two registered read ports.
// Read data holds until the next read on that port.
module dpram_core #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re) a_rdata_q <= mem_q[a_addr];
      if (b_re) b_rdata_q <= mem_q[b_addr];
      // Same-address double writes are prevented by the arbiter upstream.
      if (a_we) mem_q[a_addr] <= a_wdata;
      if (b_we) mem_q[b_addr] <= b_wdata;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/dpram_access_ctrl.sv
// Two-client access controller for a dual-port RAM: conflict arbitration with
// alternating priority, read-response pipeline and a saturating conflict counter.
module dpram_access_ctrl import dpram_pkg::*; #(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_rdata,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_rdata,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  prio_e             state_q, state_d;
  logic              conflict_now, prio_a;
  logic              acc_a, acc_b;
  logic              rsp_a_valid_q, rsp_b_valid_q, conflict_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] core_a_rdata, core_b_rdata;

  assign conflict_now = is_conflict(req_a_valid, req_b_valid, req_a_we, req_b_we,
                                    req_a_addr == req_b_addr);

  always_ff @(posedge clk) begin
    if (rst) state_q <= PRIO_A;
    else     state_q <= state_d;
  end

  // On a conflict the loser gets priority next time, so it cannot starve.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRIO_A: if (conflict_now) state_d = PRIO_B;
      PRIO_B: if (conflict_now) state_d = PRIO_A;
    endcase
  end

  always_comb begin
    prio_a      = (state_q == PRIO_A);
    req_a_ready = ~rst & (~conflict_now | prio_a);
    req_b_ready = ~rst & (~conflict_now | ~prio_a);
  end

  assign acc_a = req_a_valid & req_a_ready;
  assign acc_b = req_b_valid & req_b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
      conflict_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      rsp_a_valid_q <= acc_a & ~req_a_we;
      rsp_b_valid_q <= acc_b & ~req_b_we;
      conflict_q    <= conflict_now;
      if (conflict_now && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  dpram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .a_we    (acc_a & req_a_we),
    .a_re    (acc_a & ~req_a_we),
    .a_addr  (req_a_addr),
    .a_wdata (req_a_wdata),
    .a_rdata (core_a_rdata),
    .b_we    (acc_b & req_b_we),
    .b_re    (acc_b & ~req_b_we),
    .b_addr  (req_b_addr),
    .b_wdata (req_b_wdata),
    .b_rdata (core_b_rdata)
  );

  // Outputs read as idle for the whole reset window, including the first cycle.
  assign rsp_a_valid  = rsp_a_valid_q & ~rst;
  assign rsp_b_valid  = rsp_b_valid_q & ~rst;
  assign rsp_a_rdata  = rst ? '0 : core_a_rdata;
  assign rsp_b_rdata  = rst ? '0 : core_b_rdata;
  assign conflict     = conflict_q & ~rst;
  assign conflict_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Self-checking bench for dpram_access_ctrl: directed scenarios plus random
// traffic checked against a behavioural memory/arbitration model.
module tb_dpram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       va, wa, vb, wb;
  logic [1:0] aa, ab;
  logic [3:0] da, db;
  logic       ready_a, ready_b, rsp_a_valid, rsp_b_valid, conflict;
  logic [3:0] rsp_a_rdata, rsp_b_rdata;
  logic [7:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [3:0] m_mem [4];
  bit         m_prio_a;
  logic       m_rva, m_rvb, m_conf;
  logic [3:0] m_rda, m_rdb;
  int         m_cnt;

  always #5 clk = ~clk;

  dpram_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_a_valid  (va),
    .req_a_ready  (ready_a),
    .req_a_we     (wa),
    .req_a_addr   (aa),
    .req_a_wdata  (da),
    .rsp_a_valid  (rsp_a_valid),
    .rsp_a_rdata  (rsp_a_rdata),
    .req_b_valid  (vb),
    .req_b_ready  (ready_b),
    .req_b_we     (wb),
    .req_b_addr   (ab),
    .req_b_wdata  (db),
    .rsp_b_valid  (rsp_b_valid),
    .rsp_b_rdata  (rsp_b_rdata),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  function automatic logic m_conflict();
    return !rst && va && vb && (aa == ab) && (wa || wb);
  endfunction

  function automatic logic m_ready_a();
    return !rst && (!m_conflict() || m_prio_a);
  endfunction

  function automatic logic m_ready_b();
    return !rst && (!m_conflict() || !m_prio_a);
  endfunction

  task automatic model_update();
    logic c, ra, rb;
    c  = m_conflict();
    ra = m_ready_a();
    rb = m_ready_b();
    if (rst) begin
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      m_rva = 0; m_rvb = 0; m_rda = '0; m_rdb = '0; m_conf = 0; m_cnt = 0;
      m_prio_a = 1;
    end else begin
      m_rva = va && ra && !wa;
      m_rvb = vb && rb && !wb;
      if (m_rva) m_rda = m_mem[aa];
      if (m_rvb) m_rdb = m_mem[ab];
      if (va && ra && wa) m_mem[aa] = da;
      if (vb && rb && wb) m_mem[ab] = db;
      m_conf = c;
      if (c && m_cnt < 255) m_cnt++;
      if (c) m_prio_a = !m_prio_a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic i_va, input logic i_wa, input logic [1:0] i_aa,
                        input logic [3:0] i_da, input logic i_vb, input logic i_wb,
                        input logic [1:0] i_ab, input logic [3:0] i_db);
    va = i_va; wa = i_wa; aa = i_aa; da = i_da;
    vb = i_vb; wb = i_wb; ab = i_ab; db = i_db;
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    rst = 1;
    set_in(1, 1, 2'd0, 4'hF, 1, 1, 2'd1, 4'hE);
    tick(); tick();
    total++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", ready_a, ready_b);
    end
    total++;
    if (rsp_a_valid !== 0 || rsp_b_valid !== 0 || conflict !== 0 || conflict_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rva=%b rvb=%b conf=%b cnt=%0d want 0 0 0 0",
               rsp_a_valid, rsp_b_valid, conflict, conflict_cnt);
    end
    rst = 0;
    set_in(0, 0, 2'd0, 4'd0, 1, 0, 2'd1, 4'd0);
    set_in(1, 0, 2'd0, 4'd0, 1, 0, 2'd1, 4'd0);
    tick();
    total++;
    if (rsp_a_rdata !== 4'h0 || rsp_b_rdata !== 4'h0) begin
      bad++; $display("FAIL reset_no_write: got a=%h b=%h want 0 0", rsp_a_rdata, rsp_b_rdata);
    end
  endtask

  task automatic test_read_zero();
    for (int a = 0; a < 4; a++) begin
      set_in(1, 0, 2'(a), 4'd0, 0, 0, 2'd0, 4'd0);
      total++;
      if (ready_a !== 1'b1) begin
        bad++; $display("FAIL read_zero_ready: addr %0d got %b want 1", a, ready_a);
      end
      tick();
      total++;
      if (rsp_a_valid !== 1'b1 || rsp_a_rdata !== 4'h0 || conflict_cnt !== 8'd0) begin
        bad++;
        $display("FAIL read_zero: addr %0d got v=%b d=%h cnt=%0d want 1 0 0",
                 a, rsp_a_valid, rsp_a_rdata, conflict_cnt);
      end
    end
    idle(); tick();
    total++;
    if (rsp_a_valid !== 1'b0) begin
      bad++; $display("FAIL read_zero_single: got valid %b want 0", rsp_a_valid);
    end
  endtask

  task automatic test_dual_write();
    set_in(1, 1, 2'd1, 4'hA, 1, 1, 2'd2, 4'h5);
    total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      bad++; $display("FAIL dual_write_ready: got %b %b want 1 1", ready_a, ready_b);
    end
    tick();
    total++;
    if (rsp_a_valid !== 0 || rsp_b_valid !== 0 || conflict !== 0) begin
      bad++; $display("FAIL write_no_rsp: got %b %b conf %b want 0 0 0",
                      rsp_a_valid, rsp_b_valid, conflict);
    end
    set_in(1, 0, 2'd1, 4'd0, 1, 0, 2'd2, 4'd0);
    tick();
    total++;
    if (rsp_a_rdata !== 4'hA || rsp_b_rdata !== 4'h5 || rsp_a_valid !== 1 || rsp_b_valid !== 1) begin
      bad++; $display("FAIL dual_read: got a=%h b=%h want a 5", rsp_a_rdata, rsp_b_rdata);
    end
    idle(); tick();
    total++;
    if (rsp_a_valid !== 0 || rsp_a_rdata !== 4'hA || rsp_b_rdata !== 4'h5) begin
      bad++; $display("FAIL rdata_hold: got v=%b a=%h b=%h want 0 a 5",
                      rsp_a_valid, rsp_a_rdata, rsp_b_rdata);
    end
  endtask

  task automatic test_write_conflict();
    do_reset();
    set_in(1, 1, 2'd3, 4'h3, 1, 1, 2'd3, 4'hC);
    total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b0) begin
      bad++; $display("FAIL wconf_first: got a=%b b=%b want 1 0", ready_a, ready_b);
    end
    tick();
    total++;
    if (conflict !== 1'b1 || conflict_cnt !== 8'd1) begin
      bad++; $display("FAIL wconf_pulse: got conf=%b cnt=%0d want 1 1", conflict, conflict_cnt);
    end
    set_in(0, 0, 2'd0, 4'd0, 1, 1, 2'd3, 4'hC);
    total++;
    if (ready_b !== 1'b1) begin
      bad++; $display("FAIL wconf_loser: got ready_b=%b want 1", ready_b);
    end
    tick();
    total++;
    if (conflict !== 1'b0 || conflict_cnt !== 8'd1) begin
      bad++; $display("FAIL wconf_once: got conf=%b cnt=%0d want 0 1", conflict, conflict_cnt);
    end
    set_in(1, 0, 2'd3, 4'd0, 0, 0, 2'd0, 4'd0);
    tick();
    total++;
    if (rsp_a_rdata !== 4'hC) begin
      bad++; $display("FAIL wconf_final: got mem3=%h want c", rsp_a_rdata);
    end
  endtask

  // Relies on priority sitting at B after the previous scenario.
  task automatic test_read_write_prio_b();
    set_in(1, 0, 2'd2, 4'd0, 1, 1, 2'd2, 4'h7);
    total++;
    if (ready_a !== 1'b0 || ready_b !== 1'b1) begin
      bad++; $display("FAIL rw_prio_b: got a=%b b=%b want 0 1", ready_a, ready_b);
    end
    tick();
    set_in(1, 0, 2'd2, 4'd0, 0, 0, 2'd0, 4'd0);
    total++;
    if (ready_a !== 1'b1) begin
      bad++; $display("FAIL rw_loser: got ready_a=%b want 1", ready_a);
    end
    tick();
    total++;
    if (rsp_a_valid !== 1'b1 || rsp_a_rdata !== 4'h7 || conflict_cnt !== 8'd2) begin
      bad++; $display("FAIL rw_data: got v=%b d=%h cnt=%0d want 1 7 2",
                      rsp_a_valid, rsp_a_rdata, conflict_cnt);
    end
  endtask

  task automatic test_saturate();
    int highs = 0;
    int alt_bad = 0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      set_in(1, 1, 2'd0, 4'($urandom_range(15)), 1, 1, 2'd0, 4'($urandom_range(15)));
      if (ready_a !== ((i % 2) == 0) || ready_b !== ((i % 2) == 1)) alt_bad++;
      tick();
      if (conflict === 1'b1) highs++;
    end
    total++;
    if (alt_bad != 0) begin
      bad++; $display("FAIL sat_alternate: %0d cycles off pattern want 0", alt_bad);
    end
    total++;
    if (highs != 260) begin
      bad++; $display("FAIL sat_pulses: got %0d conflict cycles want 260", highs);
    end
    total++;
    if (conflict_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_count: got %0d want 255", conflict_cnt);
    end
    idle(); tick();
    total++;
    if (conflict !== 1'b0 || conflict_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_end: got conf=%b cnt=%0d want 0 255", conflict, conflict_cnt);
    end
  endtask

  task automatic test_reset_pending();
    set_in(1, 1, 2'd1, 4'h9, 1, 1, 2'd2, 4'h6);
    tick();
    set_in(1, 0, 2'd1, 4'd0, 1, 0, 2'd2, 4'd0);
    tick();
    rst = 1; idle();
    total++;
    if (rsp_a_valid !== 0 || rsp_b_valid !== 0 || ready_a !== 0 || ready_b !== 0) begin
      bad++; $display("FAIL rst_pending: got rva=%b rvb=%b ra=%b rb=%b want 0 0 0 0",
                      rsp_a_valid, rsp_b_valid, ready_a, ready_b);
    end
    tick();
    rst = 0; #1;
    tick();
    total++;
    if (rsp_a_valid !== 0 || rsp_b_valid !== 0) begin
      bad++; $display("FAIL rst_discard: got %b %b want 0 0", rsp_a_valid, rsp_b_valid);
    end
    for (int a = 0; a < 4; a++) begin
      set_in(1, 0, 2'(a), 4'd0, 0, 0, 2'd0, 4'd0);
      tick();
      total++;
      if (rsp_a_valid !== 1'b1 || rsp_a_rdata !== 4'h0) begin
        bad++; $display("FAIL rst_clear: addr %0d got v=%b d=%h want 1 0",
                        a, rsp_a_valid, rsp_a_rdata);
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(9) < 7), $urandom_range(1), 2'($urandom_range(3)),
             4'($urandom_range(15)), ($urandom_range(9) < 7), $urandom_range(1),
             2'($urandom_range(3)), 4'($urandom_range(15)));
      if (ready_a !== m_ready_a() || ready_b !== m_ready_b()) begin
        errs++;
        if (errs < 5) $display("FAIL rand_ready: cycle %0d got %b %b want %b %b",
                               i, ready_a, ready_b, m_ready_a(), m_ready_b());
      end
      tick();
      if (rsp_a_valid !== m_rva || rsp_b_valid !== m_rvb || rsp_a_rdata !== m_rda ||
          rsp_b_rdata !== m_rdb || conflict !== m_conf || conflict_cnt !== 8'(m_cnt)) begin
        errs++;
        if (errs < 5)
          $display("FAIL rand_rsp: cycle %0d got %b %b %h %h %b %0d want %b %b %h %h %b %0d",
                   i, rsp_a_valid, rsp_b_valid, rsp_a_rdata, rsp_b_rdata, conflict,
                   conflict_cnt, m_rva, m_rvb, m_rda, m_rdb, m_conf, m_cnt);
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rand_total: %0d mismatching cycles want 0", errs);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_read_zero();
    test_dual_write();
    test_write_conflict();
    test_read_write_prio_b();
    test_saturate();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_access_ctrl.md
DPRAM_ACCESS_CTRL -- requirements
Module: dpram_access_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 2, address width (depth = 2**ADDR_W).
REQ-002 SHALL take parameter DATA_W, default 4, data width.
REQ-003 SHALL take parameter CNT_W, default 8, conflict counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_a_valid  input  1  client A request present.
REQ-007 SHALL have port req_a_ready  output  1  client A request accepted this cycle.
REQ-008 SHALL have port req_a_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_a_addr  input  ADDR_W  client A address.
REQ-010 SHALL have port req_a_wdata  input  DATA_W  client A write data.
REQ-011 SHALL have port rsp_a_valid  output  1  client A read data valid.
REQ-012 SHALL have port rsp_a_rdata  output  DATA_W  client A read data.
REQ-013 SHALL have ports req_b_valid, req_b_ready, req_b_we, req_b_addr, req_b_wdata, rsp_b_valid and rsp_b_rdata for client B, identical to REQ-006..012.
REQ-014 SHALL have port conflict  output  1  registered pulse, one cycle after an arbitrated conflict.
REQ-015 SHALL have port conflict_cnt  output  CNT_W  saturating conflict count.

Function
REQ-016 SHALL accept a request on the clock edge where valid and ready are both 1.
REQ-017 SHALL treat a conflict as: both valid, addresses equal, at least one we=1; read/read at the same address is not a conflict.
REQ-018 SHALL drive ready combinationally: without a conflict, both readys = 1; with a conflict, only the priority client's ready = 1.
REQ-019 SHALL hold a 2-state priority FSM, PRIO_A and PRIO_B; on a conflict it moves to the losing client's state; with no conflict it holds.
REQ-020 SHALL write wdata into memory at the edge of write acceptance; a read accepted on any later cycle returns the new value.
REQ-021 SHALL assert rsp_x_valid for exactly one cycle, the cycle after read acceptance, with rsp_x_rdata = memory content before that edge.
REQ-022 SHALL handle reads on both clients in the same cycle, at the same or different addresses, concurrently with no stall.
REQ-023 SHALL handle writes on both clients in the same cycle to different addresses concurrently, both taking effect.
REQ-024 SHALL hold rsp_x_rdata at its last value while rsp_x_valid = 0, and SHALL assert no response after a write.
REQ-025 SHALL pulse conflict one cycle after each conflict cycle; N back-to-back conflict cycles give N consecutive high cycles.
REQ-026 SHALL increment conflict_cnt by 1 per conflict cycle and saturate at 2**CNT_W-1 with no wrap.
REQ-027 SHALL accept a loser that keeps its request valid no later than the next cycle, so there is no starvation.

Reset
REQ-028 SHALL, while rst = 1: clear all memory words to 0; set rsp_a_valid, rsp_b_valid and conflict to 0; set rsp_*_rdata to 0, conflict_cnt to 0 and the FSM to PRIO_A.
REQ-029 SHALL drive req_a_ready = req_b_ready = 0 while rst = 1, and SHALL perform no memory write.
REQ-030 SHALL discard any read pending when reset asserts, with no rsp_valid in the cycle after reset deasserts.

Structure
REQ-031 SHALL place the FSM state encoding (PRIO_A, PRIO_B) and default widths in shared package dpram_pkg.
REQ-032 SHALL hold the storage in one sub-module dpram_core: two synchronous write ports, two read ports, and a registered read for each port.
REQ-033 SHALL keep arbitration, FSM, response-valid pipeline and counter in dpram_access_ctrl; dpram_core holds no arbitration.

Verification
REQ-034 SHALL cover: after reset, read on A of addr 0..3 -> rsp_a_valid one cycle later, rdata = 0 each time, conflict_cnt = 0.
REQ-035 SHALL cover: A writes 0xA at addr 1 and B writes 0x5 at addr 2 in the same cycle, then both read -> A rdata 0xA, B rdata 0x5, no conflict.
REQ-036 SHALL cover: from reset, A and B both write addr 3 (A 0x3, B 0xC) held valid -> A accepted first, B the next cycle, final mem[3] = 0xC, conflict pulse 1 cycle, conflict_cnt = 1, FSM returns to PRIO_B and then holds.
REQ-037 SHALL cover: A reads addr 2 while B writes 0x7 at addr 2, FSM at PRIO_B -> B accepted first; A accepted next cycle and returns 0x7.
REQ-038 SHALL cover: 260 consecutive conflict cycles -> conflict_cnt stops at 255, conflict high for 260 cycles, readys alternate every cycle.
REQ-039 SHALL cover: rst asserted the cycle after a read acceptance -> rsp_valid stays 0, memory reads back all zeros, readys 0 during reset.
